branch_resolve_sched: RTL

Scheduler between the two branch-resolving execution units and the `branch_predict` table. It accepts up to two resolved branches per cycle, buffers them in order, and issues exactly one predictor update per cycle on the predictor's `pc_in` / `correct_branch` / `update_valid_in` port. It also raises a one-cycle redirect to fetch on any mispredict, and keeps saturating resolve and mispredict statistics.

---
 rtl/branch_resolve_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_sched.sv
// Resolved-branch scheduler: merges two resolve ports into an in-order FIFO,
// emits one predictor update per cycle, redirects fetch on mispredict, keeps stats.
module branch_resolve_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            res0_valid_in,
  input  logic [PC_W-1:0] res0_pc_in,
  input  logic [PC_W-1:0] res0_target_in,
  input  logic            res0_taken_in,
  input  logic            res0_pred_in,
  output logic            res0_ready_out,
  input  logic            res1_valid_in,
  input  logic [PC_W-1:0] res1_pc_in,
  input  logic [PC_W-1:0] res1_target_in,
  input  logic            res1_taken_in,
  input  logic            res1_pred_in,
  output logic            res1_ready_out,
  output logic            upd_valid_out,
  output logic [PC_W-1:0] upd_pc_out,
  output logic            upd_taken_out,
  output logic            redirect_out,
  output logic [PC_W-1:0] redirect_pc_out,
  output logic [15:0]     resolve_count_out,
  output logic [15:0]     mispred_count_out
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAT_W = 16;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_total;
  logic [CNT_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PC_W-1:0]   mem_pc [DEPTH];
  logic [DEPTH-1:0]  mem_taken;

  logic              acc0, acc1, mp0, mp1, pending;
  logic              w0_en, w1_en, w0_taken;
  logic [PC_W-1:0]   w0_pc;
  logic [PC_W-1:0]   redir_pc;
  logic [STAT_W:0]   res_sum, mis_sum;

  assign res0_ready_out = (count <= CNT_W'(DEPTH - 1));
  assign res1_ready_out = (count <= CNT_W'(DEPTH - 2));

  assign acc0    = res0_valid_in & res0_ready_out;
  assign acc1    = res1_valid_in & res1_ready_out;
  assign mp0     = acc0 & (res0_taken_in != res0_pred_in);
  assign mp1     = acc1 & (res1_taken_in != res1_pred_in);
  assign pending = (count != '0);

  assign wr_ptr_p1   = wr_ptr + PTR_W'(1);
  assign count_total = count + CNT_W'(acc0) + CNT_W'(acc1);
  assign count_nxt   = (count_total == '0) ? '0 : count_total - CNT_W'(1);

  // Oldest item goes to the update regs; whatever else was accepted is queued in age order.
  always_comb begin
    w0_en    = 1'b0;
    w1_en    = 1'b0;
    w0_pc    = res1_pc_in;
    w0_taken = res1_taken_in;
    if (pending) begin
      w0_en = acc0 | acc1;
      w1_en = acc0 & acc1;
      if (acc0) begin
        w0_pc    = res0_pc_in;
        w0_taken = res0_taken_in;
      end
    end else begin
      w0_en = acc0 & acc1;
    end
  end

  // Port 0 wins the single redirect slot; not-taken branches fall through to pc+4.
  always_comb begin
    redir_pc = '0;
    if (mp0) begin
      redir_pc = res0_taken_in ? res0_target_in : res0_pc_in + PC_W'(4);
    end else if (mp1) begin
      redir_pc = res1_taken_in ? res1_target_in : res1_pc_in + PC_W'(4);
    end
  end

  assign res_sum = {1'b0, resolve_count_out} + (STAT_W+1)'(acc0) + (STAT_W+1)'(acc1);
  assign mis_sum = {1'b0, mispred_count_out} + (STAT_W+1)'(mp0) + (STAT_W+1)'(mp1);

  always_ff @(posedge clk_in) begin
    if (w0_en) begin
      mem_pc[wr_ptr]    <= w0_pc;
      mem_taken[wr_ptr] <= w0_taken;
    end
    if (w1_en) begin
      mem_pc[wr_ptr_p1]    <= res1_pc_in;
      mem_taken[wr_ptr_p1] <= res1_taken_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count             <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      upd_valid_out     <= 1'b0;
      upd_pc_out        <= '0;
      upd_taken_out     <= 1'b0;
      redirect_out      <= 1'b0;
      redirect_pc_out   <= '0;
      resolve_count_out <= '0;
      mispred_count_out <= '0;
    end else begin
      count  <= count_nxt;
      wr_ptr <= wr_ptr + PTR_W'(w0_en) + PTR_W'(w1_en);
      upd_valid_out <= pending | acc0 | acc1;
      if (pending) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        upd_pc_out    <= mem_pc[rd_ptr];
        upd_taken_out <= mem_taken[rd_ptr];
      end else if (acc0) begin
        upd_pc_out    <= res0_pc_in;
        upd_taken_out <= res0_taken_in;
      end else if (acc1) begin
        upd_pc_out    <= res1_pc_in;
        upd_taken_out <= res1_taken_in;
      end
      redirect_out <= mp0 | mp1;
      if (mp0 | mp1) begin
        redirect_pc_out <= redir_pc;
      end
      resolve_count_out <= res_sum[STAT_W] ? '1 : res_sum[STAT_W-1:0];
      mispred_count_out <= mis_sum[STAT_W] ? '1 : mis_sum[STAT_W-1:0];
    end
  end

endmodule
